// File: rtl/ss_mac_pkg.sv
// Shared types and constants for the stochastic-symbol MAC sequencer.
// Holds the FSM encoding, stream limit, LFSR seeds and lane search.
package ss_mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    // 170 * 3 = 510 keeps the 9-bit accumulator from wrapping.
    localparam logic [7:0] LEN_MAX = 8'd170;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (shift-left form).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [7:0] SEED [8] = '{
        8'h01, 8'h1D, 8'h3A, 8'h5C,
        8'h77, 8'h8E, 8'hB3, 8'hE9
    };

    // Next set mask bit strictly above cur, wrapping 7 -> 0.
    // A single-bit mask returns cur itself.
    function automatic logic [2:0] next_lane(
        input logic [7:0] mask,
        input logic [2:0] cur
    );
        logic [7:0] rot;
        logic [2:0] off;
        rot = 8'({mask, mask} >> ({1'b0, cur} + 4'd1));
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return cur + 3'd1 + off;
    endfunction

endpackage

// File: rtl/ss_mac_seq_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR with seed load on reset and step enable.
// One instance per MAC lane.
module ss_lfsr8
    import ss_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] state
);

    // Shift left, feeding back the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (en) begin
            state <= {state[6:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/ss_mac_seq_ctrl.sv
// Sequencer for one stochastic-symbol MAC: clears it, walks lanes,
// supplies random numbers and hands the sum out on valid/ready.
module ss_mac_seq_ctrl
    import ss_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cyc_len,
    input  logic [7:0] lane_mask,
    output logic       busy,
    output logic [2:0] sel,
    output logic [7:0] x_randnum_0,
    output logic [7:0] x_randnum_1,
    output logic [7:0] x_randnum_2,
    output logic [7:0] x_randnum_3,
    output logic [7:0] x_randnum_4,
    output logic [7:0] x_randnum_5,
    output logic [7:0] x_randnum_6,
    output logic [7:0] x_randnum_7,
    output logic       mac_clr_n,
    input  logic [8:0] mac_z,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [8:0] result
);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [7:0] mask_q, mask_d;
    logic [2:0] sel_d;
    logic [8:0] res_d;
    logic       clr_d;
    logic [7:0] eff_len;
    logic [7:0] eff_mask;
    logic [7:0] rnd [8];

    assign eff_len  = (cyc_len > LEN_MAX) ? LEN_MAX : cyc_len;
    assign eff_mask = (lane_mask == 8'h00) ? 8'hFF : lane_mask;

    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);

    for (genvar k = 0; k < 8; k++) begin : g_lfsr
        ss_lfsr8 u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .seed  (SEED[k]),
            .en    (state == S_RUN),
            .state (rnd[k])
        );
    end

    assign x_randnum_0 = rnd[0];
    assign x_randnum_1 = rnd[1];
    assign x_randnum_2 = rnd[2];
    assign x_randnum_3 = rnd[3];
    assign x_randnum_4 = rnd[4];
    assign x_randnum_5 = rnd[5];
    assign x_randnum_6 = rnd[6];
    assign x_randnum_7 = rnd[7];

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mask_d  = mask_q;
        sel_d   = sel;
        res_d   = result;
        clr_d   = mac_clr_n;
        unique case (state)
            S_IDLE: begin
                clr_d = 1'b0;
                if (start) begin
                    mask_d  = eff_mask;
                    cnt_d   = eff_len;
                    sel_d   = next_lane(eff_mask, 3'd7);
                    clr_d   = 1'b1;
                    state_d = (eff_len != 8'd0) ? S_RUN
                                                : S_CAPTURE;
                end
            end
            S_RUN: begin
                sel_d = next_lane(mask_q, sel);
                cnt_d = cnt - 8'd1;
                if (cnt == 8'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_d   = mac_z;
                clr_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            mask_q    <= 8'd0;
            sel       <= 3'd0;
            result    <= 9'd0;
            mac_clr_n <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mask_q    <= mask_d;
            sel       <= sel_d;
            result    <= res_d;
            mac_clr_n <= clr_d;
        end
    end

endmodule

// File: tb/tb_ss_mac_seq_ctrl.sv
// Self-checking bench for ss_mac_seq_ctrl with a behavioural MAC and
// a list-based reference of lane order, LFSR streams and sums.
module tb_ss_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cyc_len;
    logic [7:0]  lane_mask;
    logic        busy;
    logic [2:0]  sel;
    logic [7:0]  rn0, rn1, rn2, rn3, rn4, rn5, rn6, rn7;
    logic        mac_clr_n;
    logic [8:0]  mac_z;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  result;
    logic [63:0] rnd_bus;

    int checks = 0;
    int failures = 0;

    logic [8:0]  xin [8];
    logic [7:0]  ref_lfsr [8];
    logic [2:0]  exp_sel [200];
    logic [63:0] exp_rnd [200];
    int          exp_n;
    logic [8:0]  exp_res;
    logic [2:0]  got_sel [200];
    logic [63:0] got_rnd [200];
    int          got_n;
    logic [8:0]  got_res;
    int          got_lat;
    int          got_clr_bad;
    int          got_hold_bad;
    bit          got_idle_ok;

    localparam logic [63:0] SEED_BUS = 64'hE9B38E775C3A1D01;

    always #5 clk = ~clk;

    ss_mac_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cyc_len     (cyc_len),
        .lane_mask   (lane_mask),
        .busy        (busy),
        .sel         (sel),
        .x_randnum_0 (rn0),
        .x_randnum_1 (rn1),
        .x_randnum_2 (rn2),
        .x_randnum_3 (rn3),
        .x_randnum_4 (rn4),
        .x_randnum_5 (rn5),
        .x_randnum_6 (rn6),
        .x_randnum_7 (rn7),
        .mac_clr_n   (mac_clr_n),
        .mac_z       (mac_z),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result)
    );

    assign rnd_bus = {rn7, rn6, rn5, rn4, rn3, rn2, rn1, rn0};

    // Symbol: MSB of x contributes 1, low byte >= random adds 2.
    function automatic int symbol(input logic [8:0] x,
                                  input logic [7:0] r);
        return int'(x[8]) + ((x[7:0] >= r) ? 2 : 0);
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1 feedback from the polynomial terms.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic fb;
        fb = s[8-1] ^ s[6-1] ^ s[5-1] ^ s[4-1];
        return {s[6:0], fb};
    endfunction

    // Behavioural MAC with asynchronous active-low clear.
    always_ff @(posedge clk or negedge mac_clr_n) begin
        if (!mac_clr_n) mac_z <= 9'd0;
        else mac_z <= mac_z + 9'(symbol(xin[sel], rnd_bus[sel*8 +: 8]));
    end

    task automatic model_run(input int len, input logic [7:0] mask);
        int L;
        int sum;
        int lanes[$];
        logic [7:0] m;
        L = (len > 170) ? 170 : len;
        m = (mask == 8'h00) ? 8'hFF : mask;
        for (int b = 0; b < 8; b++) if (m[b]) lanes.push_back(b);
        sum = 0;
        for (int i = 0; i < L; i++) begin
            int ln;
            ln = lanes[i % lanes.size()];
            exp_sel[i] = 3'(ln);
            for (int k = 0; k < 8; k++) exp_rnd[i][k*8 +: 8] = ref_lfsr[k];
            sum += symbol(xin[ln], ref_lfsr[ln]);
            for (int k = 0; k < 8; k++) ref_lfsr[k] = lfsr_next(ref_lfsr[k]);
        end
        exp_n = L;
        exp_res = 9'(sum);
    endtask

    task automatic do_run(input int len, input logic [7:0] mask,
                          input int hold, input bit poke);
        int k;
        @(negedge clk);
        start = 1'b1;
        cyc_len = 8'(len);
        lane_mask = mask;
        @(negedge clk);
        start = 1'b0;
        cyc_len = 8'($urandom);
        lane_mask = 8'($urandom);
        got_lat = 1;
        got_clr_bad = 0;
        k = 0;
        while (res_valid !== 1'b1 && got_lat < 300) begin
            if (k < 200) begin
                got_sel[k] = sel;
                got_rnd[k] = rnd_bus;
                k++;
            end
            if (mac_clr_n !== 1'b1 || busy !== 1'b1) got_clr_bad++;
            start = poke && (got_lat == 2);
            @(negedge clk);
            got_lat++;
        end
        start = 1'b0;
        got_n = k - 1;
        got_res = result;
        if (mac_clr_n !== 1'b0) got_clr_bad++;
        got_hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            start = poke;
            @(negedge clk);
            if (res_valid !== 1'b1 || result !== got_res ||
                mac_clr_n !== 1'b0) got_hold_bad++;
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        got_idle_ok = (busy === 1'b0) && (res_valid === 1'b0) &&
                      (mac_clr_n === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cyc_len = 8'd0;
        lane_mask = 8'd0;
        res_ready = 1'b0;
        for (int k = 0; k < 8; k++) xin[k] = 9'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, sel, mac_clr_n, res_valid, result} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, sel, mac_clr_n, res_valid, result});
        end
        checks++;
        if (rnd_bus !== SEED_BUS) begin
            failures++;
            $display("FAIL reset_lfsr got=%h want=%h", rnd_bus, SEED_BUS);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) ref_lfsr[k] = SEED_BUS[k*8 +: 8];
    endtask

    task automatic test_basic();
        for (int k = 0; k < 8; k++) xin[k] = 9'd256;
        model_run(10, 8'hFF);
        do_run(10, 8'hFF, 0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got_sel[i] !== exp_sel[i]) begin
                failures++;
                $display("FAIL basic_sel[%0d] got=%0d want=%0d",
                         i, got_sel[i], exp_sel[i]);
            end
        end
        checks++;
        if (got_res !== 9'd10) begin
            failures++;
            $display("FAIL basic_result got=%0d want=10", got_res);
        end
        checks++;
        if (got_lat != 12) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=12", got_lat);
        end
        checks++;
        if (!got_idle_ok || got_clr_bad != 0) begin
            failures++;
            $display("FAIL basic_handshake idle=%0d clr_bad=%0d want 1/0",
                     got_idle_ok, got_clr_bad);
        end
    endtask

    task automatic test_mask();
        for (int k = 0; k < 8; k++) xin[k] = 9'($urandom);
        model_run(6, 8'b1010_0100);
        do_run(6, 8'b1010_0100, 0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got_sel[i] !== exp_sel[i]) begin
                failures++;
                $display("FAIL mask_sel[%0d] got=%0d want=%0d",
                         i, got_sel[i], exp_sel[i]);
            end
        end
        checks++;
        if (got_res !== exp_res || got_clr_bad != 0) begin
            failures++;
            $display("FAIL mask_result got=%0d want=%0d clr_bad=%0d",
                     got_res, exp_res, got_clr_bad);
        end
    endtask

    task automatic test_clamp();
        for (int k = 0; k < 8; k++) xin[k] = 9'd511;
        model_run(255, 8'hFF);
        do_run(255, 8'hFF, 0, 1'b0);
        checks++;
        if (got_res !== 9'd510) begin
            failures++;
            $display("FAIL clamp_result got=%0d want=510", got_res);
        end
        checks++;
        if (got_lat != 172 || got_n != 170) begin
            failures++;
            $display("FAIL clamp_length lat=%0d n=%0d want=172/170",
                     got_lat, got_n);
        end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 8; k++) xin[k] = 9'd511;
        model_run(0, 8'hFF);
        do_run(0, 8'hFF, 0, 1'b0);
        checks++;
        if (got_res !== 9'd0 || got_lat != 2) begin
            failures++;
            $display("FAIL zero_len result=%0d lat=%0d want=0/2",
                     got_res, got_lat);
        end
    endtask

    task automatic test_mask_zero();
        for (int k = 0; k < 8; k++) xin[k] = 9'($urandom);
        model_run(16, 8'h00);
        do_run(16, 8'h00, 0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got_sel[i] !== exp_sel[i]) begin
                failures++;
                $display("FAIL mask0_sel[%0d] got=%0d want=%0d",
                         i, got_sel[i], exp_sel[i]);
            end
        end
        checks++;
        if (got_res !== exp_res) begin
            failures++;
            $display("FAIL mask0_result got=%0d want=%0d", got_res, exp_res);
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 8; k++) xin[k] = 9'($urandom);
        model_run(7, 8'h3C);
        do_run(7, 8'h3C, 5, 1'b1);
        checks++;
        if (got_hold_bad != 0) begin
            failures++;
            $display("FAIL hold_stable bad_cycles=%0d want=0", got_hold_bad);
        end
        checks++;
        if (got_lat != 9 || got_res !== exp_res) begin
            failures++;
            $display("FAIL hold_ignore_start lat=%0d res=%0d want=9/%0d",
                     got_lat, got_res, exp_res);
        end
        checks++;
        if (!got_idle_ok) begin
            failures++;
            $display("FAIL hold_release idle=%0d want=1", got_idle_ok);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1;
        cyc_len = 8'd20;
        lane_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || mac_clr_n !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%0d clr_n=%0d valid=%0d want=0",
                     busy, mac_clr_n, res_valid);
        end
        checks++;
        if (rnd_bus !== SEED_BUS) begin
            failures++;
            $display("FAIL abort_lfsr got=%h want=%h", rnd_bus, SEED_BUS);
        end
        for (int k = 0; k < 8; k++) ref_lfsr[k] = SEED_BUS[k*8 +: 8];
    endtask

    task automatic test_back_to_back();
        logic [7:0] first0 [4];
        for (int k = 0; k < 8; k++) xin[k] = 9'($urandom);
        for (int r = 0; r < 2; r++) begin
            model_run(4, 8'hFF);
            do_run(4, 8'hFF, 0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_rnd[i] !== exp_rnd[i]) begin
                    failures++;
                    $display("FAIL b2b_rnd[%0d][%0d] got=%h want=%h",
                             r, i, got_rnd[i], exp_rnd[i]);
                end
                if (r == 0) first0[i] = got_rnd[i][7:0];
                else begin
                    for (int j = 0; j < 4; j++) begin
                        checks++;
                        if (got_rnd[i][7:0] === first0[j]) begin
                            failures++;
                            $display("FAIL b2b_repeat got=%h want!=%h",
                                     got_rnd[i][7:0], first0[j]);
                        end
                    end
                end
            end
            checks++;
            if (got_res !== exp_res) begin
                failures++;
                $display("FAIL b2b_result[%0d] got=%0d want=%0d",
                         r, got_res, exp_res);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int len;
            logic [7:0] mask;
            len = $urandom_range(1, 40);
            mask = 8'($urandom);
            for (int k = 0; k < 8; k++) xin[k] = 9'($urandom);
            model_run(len, mask);
            do_run(len, mask, $urandom_range(0, 3), 1'b0);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (got_sel[i] !== exp_sel[i] || got_rnd[i] !== exp_rnd[i])
                begin
                    failures++;
                    $display("FAIL rand_cycle[%0d][%0d] got=%0d/%h want=%0d/%h",
                             r, i, got_sel[i], got_rnd[i],
                             exp_sel[i], exp_rnd[i]);
                end
            end
            checks++;
            if (got_res !== exp_res || got_lat != exp_n + 2) begin
                failures++;
                $display("FAIL rand_result[%0d] got=%0d lat=%0d want=%0d lat=%0d",
                         r, got_res, got_lat, exp_res, exp_n + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_clamp();
        test_zero();
        test_mask_zero();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
